metering_event_arbiter: RTL and testbench

METERING_EVENT_ARBITER -- requirements
Module: metering_event_arbiter

---
 rtl/metering_event_arbiter_if.sv | 24 ++
 rtl/metering_event_arbiter.sv | 155 +++++++++++++++
 tb/tb_metering_event_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/metering_event_arbiter_if.sv
// Handshake bundle between event requesters and the metering arbiter.
// master drives event strobes and controls; slave (the arbiter) drives pulse/status.
interface metering_event_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] ev_in;
  logic               meter_en;
  logic               ovf_clr;
  logic               metering_event;
  logic [2:0]         grant_id;
  logic               pending_any;
  logic [NUM_REQ-1:0] ovf;
  logic [31:0]        total_events;

  modport master (
    output ev_in, meter_en, ovf_clr,
    input  metering_event, grant_id, pending_any, ovf, total_events
  );

  modport slave (
    input  ev_in, meter_en, ovf_clr,
    output metering_event, grant_id, pending_any, ovf, total_events
  );
endinterface

// File: rtl/metering_event_arbiter.sv
// Round-robin arbiter turning per-requester event counts into spaced metering pulses.
// Optional macro METER_TOTAL_CNT_EN adds a 32-bit issued-pulse counter on total_events.
module metering_event_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8,
  parameter int GAP     = 2
) (
  input  logic clk,
  input  logic rst_n,
  metering_event_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   pending     [NUM_REQ];
  logic [CNT_W-1:0]   pending_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] nonzero;
  logic [NUM_REQ-1:0] ovf_set;
  logic [NUM_REQ-1:0] ovf_q;
  logic [7:0]         gap_cnt, gap_cnt_nxt;
  logic [2:0]         last_grant, winner, grant_q;
  logic               issue, any_pend, pany_nxt, pulse_q, pany_q;

  // Saturating counter step: MSB of the result flags a dropped event.
  function automatic logic [CNT_W:0] sat_step(input logic [CNT_W-1:0] cur,
                                              input logic inc, input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, cur};
    if (inc && !dec) begin
      if (cur == CNT_MAX) r = {1'b1, cur};
      else                r = {1'b0, cur + CNT_ONE};
    end else if (dec && !inc) begin
      r = {1'b0, cur - CNT_ONE};
    end
    return r;
  endfunction

  always_comb begin
    nonzero = '0;
    for (int j = 0; j < NUM_REQ; j++) nonzero[j] = |pending[j];
    any_pend = |nonzero;
  end

  // Closest nonzero requester after last_grant, measured as a rotating distance.
  always_comb begin
    int best;
    int d;
    winner = '0;
    best   = NUM_REQ;
    d      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = j - int'(last_grant) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (nonzero[j] && d < best) begin
        best   = d;
        winner = 3'(j);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    issue       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.meter_en && any_pend) begin
          issue     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP == 0) begin
          if (bus.meter_en && any_pend) issue = 1'b1;
          else                          state_nxt = ST_IDLE;
        end else begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) begin
          if (bus.meter_en && any_pend) begin
            issue     = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pany_nxt = 1'b0;
    ovf_set  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      {ovf_set[j], pending_nxt[j]} = sat_step(pending[j], bus.ev_in[j],
                                              issue && (winner == 3'(j)));
      pany_nxt = pany_nxt | (|pending_nxt[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gap_cnt    <= 8'd0;
      pulse_q    <= 1'b0;
      grant_q    <= 3'd0;
      pany_q     <= 1'b0;
      ovf_q      <= '0;
      last_grant <= 3'(NUM_REQ - 1);
      for (int j = 0; j < NUM_REQ; j++) pending[j] <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      pulse_q <= issue;
      pany_q  <= pany_nxt;
      // A same-cycle overflow overrides the clear for that bit.
      ovf_q   <= (ovf_q & ~{NUM_REQ{bus.ovf_clr}}) | ovf_set;
      for (int j = 0; j < NUM_REQ; j++) pending[j] <= pending_nxt[j];
      if (issue) begin
        grant_q    <= winner;
        last_grant <= winner;
      end
    end
  end

  assign bus.metering_event = pulse_q;
  assign bus.grant_id       = grant_q;
  assign bus.pending_any    = pany_q;
  assign bus.ovf            = ovf_q;

`ifdef METER_TOTAL_CNT_EN
  logic [31:0] total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     total_q <= 32'd0;
    else if (issue) total_q <= total_q + 32'd1;
  end

  assign bus.total_events = total_q;
`else
  assign bus.total_events = 32'd0;
`endif

endmodule

// File: tb/tb_metering_event_arbiter.sv
// Bench for metering_event_arbiter: two instances (GAP=2/CNT_W=2 and GAP=0/CNT_W=3)
// compared every cycle against an event-level reference model, plus directed scenarios.
module tb_metering_event_arbiter;
  localparam int N     = 4;
  localparam int GAP_A = 2;
  localparam int CW_A  = 2;
  localparam int GAP_B = 0;
  localparam int CW_B  = 3;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  metering_event_arbiter_if #(.NUM_REQ(N)) ifa ();
  metering_event_arbiter_if #(.NUM_REQ(N)) ifb ();

  metering_event_arbiter #(.NUM_REQ(N), .CNT_W(CW_A), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa));
  metering_event_arbiter #(.NUM_REQ(N), .CNT_W(CW_B), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb));

  // Reference model: counts per requester, round-robin pointer, and the edge of the
  // last issue; a new pulse may be decided no sooner than GAP+1 edges after the last.
  int          m_pend      [2][N];
  int          m_last      [2];
  int          m_edge      [2];
  int          m_last_edge [2];
  logic        e_ev        [2];
  int          e_gid       [2];
  logic        e_pany      [2];
  logic [N-1:0] e_ovf      [2];
  logic [31:0] e_tot       [2];

  task automatic model_reset(input int i);
    for (int j = 0; j < N; j++) m_pend[i][j] = 0;
    m_last[i]      = N - 1;
    m_edge[i]      = 0;
    m_last_edge[i] = -100;
    e_ev[i]        = 1'b0;
    e_gid[i]       = 0;
    e_pany[i]      = 1'b0;
    e_ovf[i]       = '0;
    e_tot[i]       = 32'd0;
  endtask

  task automatic model_step(input int i, input int gap, input int cmax,
                            input logic [N-1:0] ev, input logic en, input logic clr);
    int           win;
    int           idx;
    bit           anyp;
    bit           iss;
    bit           inc;
    bit           dec;
    logic [N-1:0] set;
    anyp = 0;
    for (int j = 0; j < N; j++) if (m_pend[i][j] > 0) anyp = 1;
    iss = en && anyp && (m_edge[i] >= m_last_edge[i] + gap + 1);
    win = -1;
    if (iss) begin
      for (int off = 1; off <= N; off++) begin
        idx = (m_last[i] + off) % N;
        if (win < 0 && m_pend[i][idx] > 0) win = idx;
      end
    end
    e_ev[i] = iss;
    if (iss) begin
      e_gid[i]       = win;
      m_last[i]      = win;
      m_last_edge[i] = m_edge[i];
      e_tot[i]       = e_tot[i] + 32'd1;
    end
    set = '0;
    for (int j = 0; j < N; j++) begin
      inc = ev[j];
      dec = iss && (win == j);
      if (inc && !dec) begin
        if (m_pend[i][j] == cmax) set[j] = 1'b1;
        else m_pend[i][j] = m_pend[i][j] + 1;
      end else if (dec && !inc) begin
        m_pend[i][j] = m_pend[i][j] - 1;
      end
    end
    if (clr) e_ovf[i] = '0;
    e_ovf[i] = e_ovf[i] | set;
    e_pany[i] = 1'b0;
    for (int j = 0; j < N; j++) if (m_pend[i][j] > 0) e_pany[i] = 1'b1;
    m_edge[i] = m_edge[i] + 1;
  endtask

  // Resets are only ever asserted while clk is low, so clk==1 identifies a clock edge.
  always @(posedge clk or negedge rst_a or negedge rst_b) begin
    if (!rst_a) model_reset(0);
    else if (clk) model_step(0, GAP_A, (1 << CW_A) - 1, ifa.ev_in, ifa.meter_en, ifa.ovf_clr);
    if (!rst_b) model_reset(1);
    else if (clk) model_step(1, GAP_B, (1 << CW_B) - 1, ifb.ev_in, ifb.meter_en, ifb.ovf_clr);
  end

  function automatic logic [40:0] exp_vec(input int i);
    logic [31:0] t;
`ifdef METER_TOTAL_CNT_EN
    t = e_tot[i];
`else
    t = 32'd0;
`endif
    return {e_ev[i], 3'(e_gid[i]), e_pany[i], e_ovf[i], t};
  endfunction

  function automatic logic [40:0] obs_a();
    return {ifa.metering_event, ifa.grant_id, ifa.pending_any, ifa.ovf, ifa.total_events};
  endfunction

  function automatic logic [40:0] obs_b();
    return {ifb.metering_event, ifb.grant_id, ifb.pending_any, ifb.ovf, ifb.total_events};
  endfunction

  task automatic reset_one(input int which);
    @(negedge clk);
    ifa.ev_in = '0; ifa.ovf_clr = 1'b0; ifb.ev_in = '0; ifb.ovf_clr = 1'b0;
    if (which == 0) rst_a = 1'b0; else rst_b = 1'b0;
    @(negedge clk);
    if (which == 0) rst_a = 1'b1; else rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.ev_in = '0; ifa.meter_en = 1'b1; ifa.ovf_clr = 1'b0;
    ifb.ev_in = '0; ifb.meter_en = 1'b1; ifb.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs_a() !== 41'd0) begin
      bad++; $display("FAIL reset_a got=%h want=%h", obs_a(), 41'd0);
    end
    total++;
    if (obs_b() !== 41'd0) begin
      bad++; $display("FAIL reset_b got=%h want=%h", obs_b(), 41'd0);
    end
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_single_latency();
    int pi[$];
    int pg[$];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (obs_a() !== exp_vec(0)) begin
        bad++; $display("FAIL single_model cyc=%0d got=%h want=%h", i, obs_a(), exp_vec(0));
      end
      if (ifa.metering_event === 1'b1) begin pi.push_back(i); pg.push_back(int'(ifa.grant_id)); end
      ifa.ev_in = (i == 0) ? 4'b0001 : 4'b0000;
    end
    total++;
    if (pi.size() != 1 || pi[0] != 2 || pg[0] != 0) begin
      bad++;
      $display("FAIL single_pulse got count=%0d first_cyc=%0d grant=%0d want count=1 cyc=2 grant=0",
               pi.size(), (pi.size() > 0) ? pi[0] : -1, (pg.size() > 0) ? pg[0] : -1);
    end
    total++;
    if (ifa.pending_any !== 1'b0) begin
      bad++; $display("FAIL single_pending_any got=%b want=0", ifa.pending_any);
    end
  endtask

  task automatic test_rr_gap();
    int pi[$];
    int pg[$];
    reset_one(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (obs_a() !== exp_vec(0)) begin
        bad++; $display("FAIL rr_model cyc=%0d got=%h want=%h", i, obs_a(), exp_vec(0));
      end
      if (ifa.metering_event === 1'b1) begin pi.push_back(i); pg.push_back(int'(ifa.grant_id)); end
      ifa.ev_in = (i == 0) ? 4'b1111 : 4'b0000;
    end
    total++;
    if (pi.size() != 4 || pi[0] != 2) begin
      bad++;
      $display("FAIL rr_count got count=%0d first=%0d want count=4 first=2",
               pi.size(), (pi.size() > 0) ? pi[0] : -1);
    end
    for (int k = 0; k < pi.size(); k++) begin
      total++;
      if (pg[k] != k) begin
        bad++; $display("FAIL rr_grant idx=%0d got=%0d want=%0d", k, pg[k], k);
      end
      if (k > 0) begin
        total++;
        if (pi[k] - pi[k-1] != GAP_A + 1) begin
          bad++; $display("FAIL rr_spacing idx=%0d got=%0d want=%0d", k, pi[k] - pi[k-1], GAP_A + 1);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int np;
    int wrong_gid;
    np = 0; wrong_gid = 0;
    reset_one(0);
    ifa.meter_en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      total++;
      if (obs_a() !== exp_vec(0)) begin
        bad++; $display("FAIL ovf_model cyc=%0d got=%h want=%h", i, obs_a(), exp_vec(0));
      end
      if (i == 5 || i == 6) begin
        total++;
        if (ifa.ovf !== 4'b0010) begin
          bad++; $display("FAIL ovf_set cyc=%0d got=%b want=0010", i, ifa.ovf);
        end
      end
      if (i == 8) begin
        total++;
        if (ifa.ovf !== 4'b0000) begin
          bad++; $display("FAIL ovf_clear got=%b want=0000", ifa.ovf);
        end
      end
      if (ifa.metering_event === 1'b1) begin
        np++;
        if (ifa.grant_id !== 3'd1) wrong_gid++;
      end
      ifa.ev_in    = (i <= 5) ? 4'b0010 : 4'b0000;
      ifa.ovf_clr  = (i == 5 || i == 7);
      ifa.meter_en = (i >= 8);
    end
    total++;
    if (np != 3 || wrong_gid != 0) begin
      bad++; $display("FAIL ovf_drain got pulses=%0d bad_grants=%0d want pulses=3 bad_grants=0", np, wrong_gid);
    end
  endtask

  task automatic test_back_to_back();
    int pi[$];
    int np;
    reset_one(1);
    ifb.meter_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (obs_b() !== exp_vec(1)) begin
        bad++; $display("FAIL b2b_model cyc=%0d got=%h want=%h", i, obs_b(), exp_vec(1));
      end
      if (ifb.metering_event === 1'b1) begin
        pi.push_back(i);
        total++;
        if (ifb.grant_id !== 3'd2) begin
          bad++; $display("FAIL b2b_grant cyc=%0d got=%0d want=2", i, ifb.grant_id);
        end
      end
      ifb.ev_in    = (i <= 2) ? 4'b0100 : 4'b0000;
      ifb.meter_en = (i >= 3);
    end
    total++;
    if (pi.size() != 3 || pi[0] != 4 || pi[2] != 6) begin
      bad++;
      $display("FAIL b2b_train got count=%0d first=%0d want count=3 cycles 4..6",
               pi.size(), (pi.size() > 0) ? pi[0] : -1);
    end
    reset_one(1);
    ifb.meter_en = 1'b0;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (obs_b() !== exp_vec(1)) begin
        bad++; $display("FAIL enable_drop_model cyc=%0d got=%h want=%h", i, obs_b(), exp_vec(1));
      end
      ifb.ev_in = (i <= 2) ? 4'b0100 : 4'b0000;
      if (ifb.metering_event === 1'b1) begin
        np++;
        ifb.meter_en = 1'b0;
      end else if (i == 3) begin
        ifb.meter_en = 1'b1;
      end
    end
    total++;
    if (np != 1) begin
      bad++; $display("FAIL enable_drop got pulses=%0d want=1", np);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int np;
    found = 0; np = 0;
    reset_one(1);
    ifb.meter_en = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      total++;
      if (obs_b() !== exp_vec(1)) begin
        bad++; $display("FAIL rstmid_model cyc=%0d got=%h want=%h", i, obs_b(), exp_vec(1));
      end
      if (ifb.metering_event === 1'b1) begin
        found = 1;
        rst_b = 1'b0;
        #1;
        total++;
        if (ifb.metering_event !== 1'b0) begin
          bad++; $display("FAIL rstmid_pulse got=%b want=0", ifb.metering_event);
        end
        total++;
        if (obs_b() !== 41'd0) begin
          bad++; $display("FAIL rstmid_outputs got=%h want=%h", obs_b(), 41'd0);
        end
      end else begin
        ifb.ev_in    = (i < 5) ? 4'b0001 : 4'b0000;
        ifb.meter_en = (i >= 5);
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rstmid_timeout got=no pulse want=pulse within 20 cycles");
    end
    @(negedge clk);
    rst_b = 1'b1;
    ifb.ev_in = '0;
    ifb.meter_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (obs_b() !== exp_vec(1)) begin
        bad++; $display("FAIL rstmid_after_model cyc=%0d got=%h want=%h", i, obs_b(), exp_vec(1));
      end
      if (ifb.metering_event === 1'b1) np++;
    end
    total++;
    if (np != 0) begin
      bad++; $display("FAIL rstmid_after got pulses=%0d want=0", np);
    end
  endtask

  task automatic test_total_count();
    int np;
    logic [31:0] want;
    np = 0;
    reset_one(1);
    ifb.meter_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (obs_b() !== exp_vec(1)) begin
        bad++; $display("FAIL total_model cyc=%0d got=%h want=%h", i, obs_b(), exp_vec(1));
      end
      if (ifb.metering_event === 1'b1) np++;
      ifb.ev_in = (i < 5) ? 4'b0011 : 4'b0000;
    end
`ifdef METER_TOTAL_CNT_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    total++;
    if (np != 10) begin
      bad++; $display("FAIL total_pulses got=%0d want=10", np);
    end
    total++;
    if (ifb.total_events !== want) begin
      bad++; $display("FAIL total_events got=%0d want=%0d", ifb.total_events, want);
    end
  endtask

  task automatic test_random();
    reset_one(0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      total++;
      if (obs_a() !== exp_vec(0)) begin
        bad++; $display("FAIL rand_a cyc=%0d got=%h want=%h", i, obs_a(), exp_vec(0));
      end
      ifa.ev_in    = 4'($urandom & $urandom);
      ifa.meter_en = ($urandom_range(0, 9) != 0);
      ifa.ovf_clr  = ($urandom_range(0, 15) == 0);
    end
    ifa.ev_in = '0; ifa.ovf_clr = 1'b0;
    reset_one(1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      total++;
      if (obs_b() !== exp_vec(1)) begin
        bad++; $display("FAIL rand_b cyc=%0d got=%h want=%h", i, obs_b(), exp_vec(1));
      end
      ifb.ev_in    = 4'($urandom);
      ifb.meter_en = ($urandom_range(0, 5) != 0);
      ifb.ovf_clr  = ($urandom_range(0, 15) == 0);
    end
    ifb.ev_in = '0; ifb.ovf_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_latency();
    test_rr_gap();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_total_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
